// File: rtl/fifo_rd_checker_if.sv
// fifo_rd_checker_if: FIFO read-port bundle (pop strobe, empty flag, fall-through data).
// master = consumer that pops, slave = FIFO read side.
interface fifo_rd_checker_if #(
    parameter int DSIZE = 16
);
    logic             rinc;
    logic             rempty;
    logic [DSIZE-1:0] rdata;
    modport master (output rinc, input rempty, input rdata);
    modport slave  (input rinc, output rempty, output rdata);
endinterface

// File: rtl/fifo_rd_checker.sv
// fifo_rd_checker: pops a first-word-fall-through FIFO and checks an incrementing stream from SEED.
// Optional LFSR pop throttling with input throttle_i is compiled in by defining RDCHK_THROTTLE_EN.
module fifo_rd_checker #(
    parameter int               DSIZE   = 16,
    parameter int               CW      = 32,
    parameter logic [DSIZE-1:0] SEED    = '0,
    parameter int               NWORDS  = 0,
    parameter int               TIMEOUT = 1024
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
`ifdef RDCHK_THROTTLE_EN
    input  logic [7:0]       throttle_i,
`endif
    fifo_rd_checker_if.master rd,
    output logic [CW-1:0]    pop_count_o,
    output logic [CW-1:0]    err_count_o,
    output logic             err_o,
    output logic [DSIZE-1:0] first_bad_o,
    output logic [DSIZE-1:0] first_exp_o,
    output logic             stall_o,
    output logic             done_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [DSIZE-1:0] exp_q, exp_d, first_bad_q, first_bad_d, first_exp_q, first_exp_d;
    logic [CW-1:0]    pop_q, pop_d, err_cnt_q, err_cnt_d;
    logic             err_q, err_d, stall_q, stall_d;
    logic [31:0]      empty_q, empty_d;
    logic             allow, pop, mismatch, wd_tick;

`ifdef RDCHK_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = (state_q == RUN) ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
    assign allow  = lfsr_q[7:0] >= throttle_i;
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign allow = 1'b1;
`endif

    assign pop      = (state_q == RUN) & ~rd.rempty & ~clr_i & allow;
    assign rd.rinc  = pop;
    assign mismatch = rd.rdata != exp_q;
    // throttled cycles are not starvation, so they neither advance nor clear the watchdog
    assign wd_tick  = (state_q == RUN) & rd.rempty & allow;

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        first_bad_d = first_bad_q;
        first_exp_d = first_exp_q;
        pop_d       = pop_q;
        err_cnt_d   = err_cnt_q;
        err_d       = err_q;
        empty_d     = wd_tick ? ((empty_q < 32'(TIMEOUT)) ? empty_q + 32'd1 : empty_q)
                    : ((state_q == RUN) && rd.rempty) ? empty_q : '0;
        stall_d     = stall_q | ((TIMEOUT != 0) && wd_tick && (empty_d == 32'(TIMEOUT)));
        if (state_q == IDLE && en_i) state_d = RUN;
        else if (state_q == RUN && !en_i) state_d = IDLE;
        if (pop) begin
            pop_d = pop_q + CW'(1);
            exp_d = mismatch ? rd.rdata + DSIZE'(1) : exp_q + DSIZE'(1);
            if (mismatch) begin
                err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + CW'(1);
                err_d     = 1'b1;
                first_bad_d = err_q ? first_bad_q : rd.rdata;
                first_exp_d = err_q ? first_exp_q : exp_q;
            end
            if (NWORDS > 0 && pop_d == CW'(NWORDS)) state_d = DONE;
        end
        if (clr_i) begin
            state_d     = IDLE;
            exp_d       = SEED;
            first_bad_d = '0;
            first_exp_d = '0;
            pop_d       = '0;
            err_cnt_d   = '0;
            err_d       = 1'b0;
            stall_d     = 1'b0;
            empty_d     = '0;
        end
    end

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            exp_q       <= SEED;
            first_bad_q <= '0;
            first_exp_q <= '0;
            pop_q       <= '0;
            err_cnt_q   <= '0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
            empty_q     <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            first_bad_q <= first_bad_d;
            first_exp_q <= first_exp_d;
            pop_q       <= pop_d;
            err_cnt_q   <= err_cnt_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
            empty_q     <= empty_d;
        end
    end

    assign pop_count_o = pop_q;
    assign err_count_o = err_cnt_q;
    assign err_o       = err_q;
    assign first_bad_o = first_bad_q;
    assign first_exp_o = first_exp_q;
    assign stall_o     = stall_q;
    assign done_o      = state_q == DONE;
endmodule

// File: tb/tb_fifo_rd_checker.sv
// tb_fifo_rd_checker: two checker instances fed by queue-based FIFO models; a scoreboard entry
// (expected pop/error counts) is queued per written word and popped by a monitor on every rinc.
module tb_fifo_rd_checker;
    localparam int DW = 16;
    localparam int CW = 32;

    typedef struct packed {
        logic [CW-1:0] pc;
        logic [CW-1:0] ec;
    } exp_t;

    logic rclk = 1'b0;
    logic reset = 1'b1;
    logic en_a = 1'b0, clr_a = 1'b0, en_b = 1'b0, clr_b = 1'b0;
    logic [7:0] thr = 8'h00;
    logic [CW-1:0] pop_a, ecnt_a, pop_b, ecnt_b;
    logic [DW-1:0] fbad_a, fexp_a, fbad_b, fexp_b;
    logic err_a, stall_a, done_a, err_b, stall_b, done_b;
    int vectors = 0, miscompares = 0, empty_pops = 0;
    logic [DW-1:0] qa[$], qb[$];
    exp_t sba[$], sbb[$];
    logic [DW-1:0] mexp_a = 16'h0000, mexp_b = 16'hFFFE;
    logic [CW-1:0] mpc_a = '0, mec_a = '0, mpc_b = '0, mec_b = '0;

    fifo_rd_checker_if #(.DSIZE(DW)) ifa ();
    fifo_rd_checker_if #(.DSIZE(DW)) ifb ();

    always #5 rclk = ~rclk;

    fifo_rd_checker #(.DSIZE(DW), .CW(CW), .SEED(16'h0000), .NWORDS(0), .TIMEOUT(16)) dut_a (
        .rclk(rclk), .reset(reset), .en_i(en_a), .clr_i(clr_a),
`ifdef RDCHK_THROTTLE_EN
        .throttle_i(thr),
`endif
        .rd(ifa), .pop_count_o(pop_a), .err_count_o(ecnt_a), .err_o(err_a),
        .first_bad_o(fbad_a), .first_exp_o(fexp_a), .stall_o(stall_a), .done_o(done_a));

    fifo_rd_checker #(.DSIZE(DW), .CW(CW), .SEED(16'hFFFE), .NWORDS(8), .TIMEOUT(0)) dut_b (
        .rclk(rclk), .reset(reset), .en_i(en_b), .clr_i(clr_b),
`ifdef RDCHK_THROTTLE_EN
        .throttle_i(thr),
`endif
        .rd(ifb), .pop_count_o(pop_b), .err_count_o(ecnt_b), .err_o(err_b),
        .first_bad_o(fbad_b), .first_exp_o(fexp_b), .stall_o(stall_b), .done_o(done_b));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        ifa.rempty = qa.size() == 0;
        ifa.rdata  = (qa.size() > 0) ? qa[0] : '0;
        ifb.rempty = qb.size() == 0;
        ifb.rdata  = (qb.size() > 0) ? qb[0] : '0;
    endtask

    task automatic push_a(input logic [DW-1:0] w);
        mpc_a++;
        if (w != mexp_a) mec_a++;
        mexp_a = w + 16'd1;
        sba.push_back({mpc_a, mec_a});
        qa.push_back(w);
    endtask

    task automatic push_b(input logic [DW-1:0] w);
        mpc_b++;
        if (w != mexp_b) mec_b++;
        mexp_b = w + 16'd1;
        sbb.push_back({mpc_b, mec_b});
        qb.push_back(w);
    endtask

    task automatic flush_a();
        mexp_a = 16'h0000; mpc_a = '0; mec_a = '0;
        sba.delete(); qa.delete();
    endtask

    task automatic flush_b();
        mexp_b = 16'hFFFE; mpc_b = '0; mec_b = '0;
        sbb.delete(); qb.delete();
    endtask

    task automatic drain_a(input string name);
        int n = 0;
        while ((qa.size() > 0 || sba.size() > 0) && n < 2000) begin
            @(negedge rclk);
            n++;
        end
        check({name, " drained"}, 64'(n < 2000), 64'd1);
        @(negedge rclk);
    endtask

    task automatic clear_a();
        @(negedge rclk);
        en_a = 1'b0; clr_a = 1'b1;
        @(negedge rclk);
        clr_a = 1'b0;
        flush_a();
    endtask

    // FIFO read-side models: pop on rinc, present head word away from the clock edge
    initial begin
        bit pa, pb;
        refresh();
        forever begin
            @(posedge rclk);
            pa = ifa.rinc; pb = ifb.rinc;
            #1;
            if (pa && qa.size() > 0) void'(qa.pop_front());
            if (pb && qb.size() > 0) void'(qb.pop_front());
            refresh();
            @(negedge rclk);
            #1;
            refresh();
        end
    end

    initial begin
        bit p, e;
        exp_t x;
        forever begin
            @(posedge rclk);
            p = ifa.rinc; e = ifa.rempty;
            #1;
            if (p && e) empty_pops++;
            if (p) begin
                if (sba.size() == 0) check("a unexpected pop", 64'd1, 64'd0);
                else begin
                    x = sba.pop_front();
                    check("a pop_count", 64'(pop_a), 64'(x.pc));
                    check("a err_count", 64'(ecnt_a), 64'(x.ec));
                end
            end
        end
    end

    initial begin
        bit p, e;
        exp_t x;
        forever begin
            @(posedge rclk);
            p = ifb.rinc; e = ifb.rempty;
            #1;
            if (p && e) empty_pops++;
            if (p) begin
                if (sbb.size() == 0) check("b unexpected pop", 64'd1, 64'd0);
                else begin
                    x = sbb.pop_front();
                    check("b pop_count", 64'(pop_b), 64'(x.pc));
                    check("b err_count", 64'(ecnt_b), 64'(x.ec));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge rclk);
        check("reset pop_count", 64'(pop_a), 64'd0);
        check("reset err_count", 64'(ecnt_a), 64'd0);
        check("reset err_o", 64'(err_a), 64'd0);
        check("reset first_bad", 64'(fbad_a), 64'd0);
        check("reset first_exp", 64'(fexp_a), 64'd0);
        check("reset stall_o", 64'(stall_a), 64'd0);
        check("reset done_o", 64'(done_a), 64'd0);
        check("reset rinc", 64'(ifa.rinc), 64'd0);
        reset = 1'b0;

        // clean stream 0..99
        @(negedge rclk);
        en_a = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge rclk);
            push_a(16'(i));
        end
        drain_a("stream100");
        check("stream100 pop_count", 64'(pop_a), 64'd100);
        check("stream100 err_count", 64'(ecnt_a), 64'd0);
        check("stream100 err_o", 64'(err_a), 64'd0);

        // dropped word 5
        clear_a();
        check("clr pop_count", 64'(pop_a), 64'd0);
        en_a = 1'b1;
        for (int i = 0; i < 10; i++) if (i != 5) begin
            @(negedge rclk);
            push_a(16'(i));
        end
        drain_a("skip5");
        check("skip5 pop_count", 64'(pop_a), 64'd9);
        check("skip5 err_count", 64'(ecnt_a), 64'd1);
        check("skip5 err_o", 64'(err_a), 64'd1);
        check("skip5 first_exp", 64'(fexp_a), 64'h5);
        check("skip5 first_bad", 64'(fbad_a), 64'h6);

        // watchdog: 16 consecutive empty RUN cycles
        clear_a();
        en_a = 1'b1;
        check("clr err_o", 64'(err_a), 64'd0);
        check("clr first_bad", 64'(fbad_a), 64'd0);
        repeat (16) @(negedge rclk);
        check("wd stall at 15", 64'(stall_a), 64'd0);
        @(negedge rclk);
        check("wd stall at 16", 64'(stall_a), 64'd1);
        en_a = 1'b0;
        repeat (5) @(negedge rclk);
        check("wd stall sticky", 64'(stall_a), 64'd1);
        clear_a();
        check("wd stall cleared", 64'(stall_a), 64'd0);

        // async reset mid-stream, then restart from SEED
        en_a = 1'b1;
        @(negedge rclk);
        for (int i = 0; i < 10; i++) push_a(16'(i));
        repeat (4) @(negedge rclk);
        check("midstream words left", 64'(qa.size() > 0), 64'd1);
        reset = 1'b1;
        flush_a();
        #1;
        check("async reset rinc", 64'(ifa.rinc), 64'd0);
        check("async reset pop_count", 64'(pop_a), 64'd0);
        check("async reset err_o", 64'(err_a), 64'd0);
        @(negedge rclk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge rclk);
            push_a(16'(i));
        end
        drain_a("restart");
        check("restart pop_count", 64'(pop_a), 64'd20);
        check("restart err_count", 64'(ecnt_a), 64'd0);

        // NWORDS=8 with SEED=FFFE: wraps FFFE,FFFF,0000,... and stops after 8 pops
        en_a = 1'b0;
        @(negedge rclk);
        en_b = 1'b1;
        for (int i = 0; i < 20; i++) push_b(16'hFFFE + 16'(i));
        n = 0;
        while (!done_b && n < 100) begin
            @(negedge rclk);
            n++;
        end
        check("nwords done_o", 64'(done_b), 64'd1);
        repeat (5) @(negedge rclk);
        check("nwords pop_count", 64'(pop_b), 64'd8);
        check("nwords wrap err_count", 64'(ecnt_b), 64'd0);
        check("nwords words left", 64'(qb.size()), 64'd12);
        check("nwords rinc after done", 64'(ifb.rinc), 64'd0);
        check("nwords done held", 64'(done_b), 64'd1);
        en_b = 1'b0; clr_b = 1'b1;
        @(negedge rclk);
        clr_b = 1'b0;
        flush_b();
        check("nwords clr done_o", 64'(done_b), 64'd0);
        check("nwords clr pop_count", 64'(pop_b), 64'd0);
        en_b = 1'b1;
        repeat (40) @(negedge rclk);
        check("timeout0 no stall", 64'(stall_b), 64'd0);
        en_b = 1'b0;

`ifdef RDCHK_THROTTLE_EN
        clear_a();
        thr = 8'h80;
        en_a = 1'b1;
        @(negedge rclk);
        for (int i = 0; i < 40; i++) push_a(16'(i));
        drain_a("throttle");
        check("throttle pop_count", 64'(pop_a), 64'd40);
        check("throttle err_count", 64'(ecnt_a), 64'd0);
        thr = 8'h00;
`endif

        check("rinc while empty", 64'(empty_pops), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
